rat_int_ctrl: RTL and testbench

- Interrupt source side of the RAT CPU interrupt handshake.
- Synchronises up to 8 external interrupt lines, latches rising edges as pending, and applies a software mask. Drives INTV to the control unit and tracks the source being serviced until the ISR writes end-of-interrupt (EOI).
- Software accesses it through the CPU IO-port bus (PORT_ID / OUT_PORT / IO_STRB / IN_PORT).

---
 rtl/rat_int_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_rat_int_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rat_int_ctrl.sv
// rat_int_ctrl: interrupt source side of the RAT CPU interrupt handshake.
// Latency: IRQ rise -> PEND 3 clk, PEND -> INTV 1 clk, EOI -> re-raised INTV 2 clk.
// Backpressure: none; INTV holds until INT_ACK, and edges keep landing in PEND while a source is serviced.
//
// Ports:
//   clk, RESET            rising-edge clock, asynchronous active-high reset
//   IRQ[N_SRC-1:0]        asynchronous external interrupt lines (bit 0 = highest priority)
//   PORT_ID, OUT_PORT     CPU IO-port address and write data
//   IO_STRB               one-cycle CPU write strobe
//   INT_ACK               one-cycle pulse while the control unit takes the interrupt
//   INTV                  registered interrupt request to the control unit
//   IN_DATA, IN_SEL       read data and hit flag for the top-level IN_PORT mux
//   INT_ACTIVE, ACTIVE_ID source currently being serviced
//
// Port map (offsets from PORT_BASE):
//   +0 PEND   read; write-1-to-clear
//   +1 MASK   read/write, 1 = enabled
//   +2 {5'b0, ACTIVE_ID} read; any write is end-of-interrupt (EOI)
//   +3 missed-interrupt counter when built with RAT_INT_MISS_CNT_EN, otherwise reads 0
//
// Optional feature macro: RAT_INT_MISS_CNT_EN (8-bit saturating missed-edge counter).

module rat_int_ctrl #(
  parameter int         N_SRC     = 4,
  parameter logic [7:0] PORT_BASE = 8'hE0
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic [N_SRC-1:0] IRQ,
  input  logic [7:0]       PORT_ID,
  input  logic [7:0]       OUT_PORT,
  input  logic             IO_STRB,
  input  logic             INT_ACK,
  output logic             INTV,
  output logic [7:0]       IN_DATA,
  output logic             IN_SEL,
  output logic             INT_ACTIVE,
  output logic [2:0]       ACTIVE_ID
);

  // Bits at or above N_SRC never store anything, so they read 0 and ignore writes.
  function automatic logic [7:0] src_mask_f();
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < N_SRC; i++) m[i] = 1'b1;
    return m;
  endfunction

  localparam logic [7:0] SRC_MASK = src_mask_f();

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic [7:0] irq_ext;
  logic [7:0] sync1;
  logic [7:0] sync2;
  logic [7:0] dly;
  logic [7:0] rise;

  logic [7:0] pend;
  logic [7:0] pend_nxt;
  logic [7:0] mask;
  logic [7:0] req_vec;
  logic       req;

  logic [2:0] pick_id;
  logic [7:0] pick_bit;
  logic       ack_take;

  logic [7:0] port_off;
  logic       port_hit;
  logic       wr_pend;
  logic       wr_mask;
  logic       wr_eoi;
  logic [7:0] miss_rd;

  logic       intv_q;
  logic [2:0] active_id_q;

  // ---------------------------------------------------------------------
  // Input path: widen IRQ to a byte, 2-flop synchroniser, then a delay
  // flop so a rising edge shows up as a single-cycle rise pulse.
  // ---------------------------------------------------------------------
  always_comb begin
    irq_ext = '0;
    for (int i = 0; i < N_SRC; i++) irq_ext[i] = IRQ[i];
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      sync1 <= '0;
      sync2 <= '0;
      dly   <= '0;
    end else begin
      sync1 <= irq_ext;
      sync2 <= sync1;
      dly   <= sync2;
    end
  end

  assign rise = sync2 & ~dly;

  // ---------------------------------------------------------------------
  // IO port decode. Subtracting the base (rather than comparing the top
  // six bits) keeps the decode correct for a base that is not 4-aligned.
  // ---------------------------------------------------------------------
  assign port_off = PORT_ID - PORT_BASE;
  assign port_hit = (port_off < 8'd4);

  assign wr_pend = IO_STRB && port_hit && (port_off[1:0] == 2'd0);
  assign wr_mask = IO_STRB && port_hit && (port_off[1:0] == 2'd1);
  assign wr_eoi  = IO_STRB && port_hit && (port_off[1:0] == 2'd2);

  // ---------------------------------------------------------------------
  // Request and fixed priority: lowest enabled pending index wins. The
  // scan runs high-to-low so the last assignment is the lowest index.
  // MASK is the registered value, so a MASK write in the same cycle as
  // INT_ACK does not influence the choice.
  // ---------------------------------------------------------------------
  assign req_vec = pend & mask;
  assign req     = |req_vec;

  always_comb begin
    pick_id = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req_vec[i]) pick_id = 3'(i);
    end
  end

  assign pick_bit = 8'h01 << pick_id;

  // ---------------------------------------------------------------------
  // Handshake state machine
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ack_take  = 1'b0;
    case (state)
      IDLE: begin
        if (req) state_nxt = REQUEST;
      end
      REQUEST: begin
        // A request withdrawn by masking or W1C falls back to IDLE without an ack.
        if (!req) begin
          state_nxt = IDLE;
        end else if (INT_ACK) begin
          state_nxt = ACTIVE;
          ack_take  = 1'b1;
        end
      end
      ACTIVE: begin
        // No nesting: further requests wait until the ISR writes EOI.
        if (wr_eoi) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // INTV comes straight from a flop so the control unit never sees a glitch.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) intv_q <= 1'b0;
    else       intv_q <= (state_nxt == REQUEST);
  end

  assign INTV       = intv_q;
  assign INT_ACTIVE = (state == ACTIVE);

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET)         active_id_q <= 3'd0;
    else if (ack_take) active_id_q <= pick_id;
  end

  assign ACTIVE_ID = active_id_q;

  // ---------------------------------------------------------------------
  // PEND and MASK. Clears (W1C or ack) are applied before the set, so a
  // new edge on the same bit in the same cycle always stays pending.
  // ---------------------------------------------------------------------
  always_comb begin
    pend_nxt = pend;
    if (wr_pend)  pend_nxt = pend_nxt & ~OUT_PORT;
    if (ack_take) pend_nxt = pend_nxt & ~pick_bit;
    pend_nxt = (pend_nxt | rise) & SRC_MASK;
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      pend <= '0;
      mask <= '0;
    end else begin
      pend <= pend_nxt;
      if (wr_mask) mask <= OUT_PORT & SRC_MASK;
    end
  end

  // ---------------------------------------------------------------------
  // Missed-interrupt counter: an edge arriving on a source that is still
  // pending is lost, since PEND can only record one occurrence.
  // ---------------------------------------------------------------------
`ifdef RAT_INT_MISS_CNT_EN
  logic [7:0] miss_cnt;
  logic       miss_evt;
  logic       wr_miss;

  assign miss_evt = |(rise & pend);
  assign wr_miss  = IO_STRB && port_hit && (port_off[1:0] == 2'd3);

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      miss_cnt <= 8'h00;
    end else if (wr_miss) begin
      miss_cnt <= 8'h00;
    end else if (miss_evt && (miss_cnt != 8'hFF)) begin
      miss_cnt <= miss_cnt + 8'h01;
    end
  end

  assign miss_rd = miss_cnt;
`else
  assign miss_rd = 8'h00;
`endif

  // ---------------------------------------------------------------------
  // Read mux. All four ports are readable, so IN_SEL covers +3 even when
  // the counter is not built.
  // ---------------------------------------------------------------------
  always_comb begin
    IN_DATA = 8'h00;
    IN_SEL  = port_hit;
    if (port_hit) begin
      case (port_off[1:0])
        2'd0:    IN_DATA = pend;
        2'd1:    IN_DATA = mask;
        2'd2:    IN_DATA = {5'b00000, active_id_q};
        default: IN_DATA = miss_rd;
      endcase
    end
  end

endmodule

// File: tb/tb_rat_int_ctrl.sv
// Bench for rat_int_ctrl: register-access vector table followed by hand-written
// interrupt handshake sequences. Read expectations go through a scoreboard queue.

module tb_rat_int_ctrl;

  localparam int         N_SRC = 4;
  localparam logic [7:0] BASE  = 8'hE0;

`ifdef RAT_INT_MISS_CNT_EN
  localparam bit MISS_EN = 1'b1;
`else
  localparam bit MISS_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             RESET;
  logic [N_SRC-1:0] IRQ;
  logic [7:0]       PORT_ID;
  logic [7:0]       OUT_PORT;
  logic             IO_STRB;
  logic             INT_ACK;
  logic             INTV;
  logic [7:0]       IN_DATA;
  logic             IN_SEL;
  logic             INT_ACTIVE;
  logic [2:0]       ACTIVE_ID;

  rat_int_ctrl #(.N_SRC(N_SRC), .PORT_BASE(BASE)) dut (
    .clk        (clk),
    .RESET      (RESET),
    .IRQ        (IRQ),
    .PORT_ID    (PORT_ID),
    .OUT_PORT   (OUT_PORT),
    .IO_STRB    (IO_STRB),
    .INT_ACK    (INT_ACK),
    .INTV       (INTV),
    .IN_DATA    (IN_DATA),
    .IN_SEL     (IN_SEL),
    .INT_ACTIVE (INT_ACTIVE),
    .ACTIVE_ID  (ACTIVE_ID)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         wr;
    logic [7:0] port;
    logic [7:0] data;
    logic [7:0] exp_dat;
    bit         exp_sel;
    string      name;
  } vec_t;

  typedef struct {
    logic [7:0] dat;
    bit         sel;
    string      name;
  } exp_t;

  vec_t vtab[$];
  exp_t sb[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic io_write(input logic [7:0] port, input logic [7:0] data);
    PORT_ID  = port;
    OUT_PORT = data;
    IO_STRB  = 1'b1;
    step();
    IO_STRB  = 1'b0;
    PORT_ID  = 8'h00;
  endtask

  // Expected read result is queued when the address is driven and popped
  // when the combinational read data is sampled.
  task automatic rd(input logic [7:0] port, input logic [7:0] exp_dat,
                    input bit exp_sel, input string name);
    exp_t e;
    PORT_ID = port;
    sb.push_back('{dat: exp_dat, sel: exp_sel, name: name});
    #1;
    e = sb.pop_front();
    check({e.name, "_data"}, IN_DATA, e.dat);
    check({e.name, "_sel"}, {7'b0, IN_SEL}, {7'b0, e.sel});
    PORT_ID = 8'h00;
  endtask

  task automatic ack();
    INT_ACK = 1'b1;
    step();
    INT_ACK = 1'b0;
  endtask

  initial begin
    RESET    = 1'b1;
    IRQ      = '0;
    PORT_ID  = 8'h00;
    OUT_PORT = 8'h00;
    IO_STRB  = 1'b0;
    INT_ACK  = 1'b0;

    vtab.push_back('{1'b0, BASE+8'd0, 8'h00, 8'h00, 1'b1, "rst_pend"});
    vtab.push_back('{1'b0, BASE+8'd1, 8'h00, 8'h00, 1'b1, "rst_mask"});
    vtab.push_back('{1'b0, BASE+8'd2, 8'h00, 8'h00, 1'b1, "rst_id"});
    vtab.push_back('{1'b0, BASE+8'd3, 8'h00, 8'h00, 1'b1, "rst_p3"});
    vtab.push_back('{1'b1, BASE+8'd1, 8'hFF, 8'h00, 1'b0, "wr_mask_ff"});
    vtab.push_back('{1'b0, BASE+8'd1, 8'h00, 8'h0F, 1'b1, "mask_upper_ignored"});
    vtab.push_back('{1'b1, BASE+8'd1, 8'h0A, 8'h00, 1'b0, "wr_mask_0a"});
    vtab.push_back('{1'b0, BASE+8'd1, 8'h00, 8'h0A, 1'b1, "mask_rw"});
    vtab.push_back('{1'b1, BASE+8'd0, 8'hFF, 8'h00, 1'b0, "w1c_empty"});
    vtab.push_back('{1'b0, BASE+8'd0, 8'h00, 8'h00, 1'b1, "pend_after_w1c"});
    vtab.push_back('{1'b1, BASE+8'd2, 8'h55, 8'h00, 1'b0, "eoi_in_idle"});
    vtab.push_back('{1'b0, BASE+8'd2, 8'h00, 8'h00, 1'b1, "id_after_idle_eoi"});
    vtab.push_back('{1'b0, 8'hE4,     8'h00, 8'h00, 1'b0, "miss_above"});
    vtab.push_back('{1'b0, 8'hDF,     8'h00, 8'h00, 1'b0, "miss_below"});
    vtab.push_back('{1'b1, 8'hE5,     8'hFF, 8'h00, 1'b0, "foreign_write"});
    vtab.push_back('{1'b0, BASE+8'd1, 8'h00, 8'h0A, 1'b1, "mask_after_foreign"});
    vtab.push_back('{1'b1, BASE+8'd3, 8'h12, 8'h00, 1'b0, "wr_p3"});
    vtab.push_back('{1'b0, BASE+8'd3, 8'h00, 8'h00, 1'b1, "p3_after_wr"});

    // Reset state of the handshake outputs
    step(2);
    check("rst_intv", {7'b0, INTV}, 8'h00);
    check("rst_int_active", {7'b0, INT_ACTIVE}, 8'h00);
    check("rst_active_id", {5'b0, ACTIVE_ID}, 8'h00);
    RESET = 1'b0;
    step();

    // Register access table
    foreach (vtab[i]) begin
      if (vtab[i].wr) begin
        io_write(vtab[i].port, vtab[i].data);
      end else begin
        rd(vtab[i].port, vtab[i].exp_dat, vtab[i].exp_sel, vtab[i].name);
        step();
      end
    end
    check("tab_intv", {7'b0, INTV}, 8'h00);
    check("tab_int_active", {7'b0, INT_ACTIVE}, 8'h00);

    // Basic request / ack / EOI on source 0
    io_write(BASE + 8'd1, 8'h01);
    IRQ = 4'b0001;
    step(2);
    rd(BASE, 8'h00, 1'b1, "s1_pend_early");
    step();
    rd(BASE, 8'h01, 1'b1, "s1_pend");
    check("s1_intv_early", {7'b0, INTV}, 8'h00);
    step();
    check("s1_intv", {7'b0, INTV}, 8'h01);
    step();
    IRQ = 4'b0000;
    ack();
    check("s1_active_id", {5'b0, ACTIVE_ID}, 8'h00);
    check("s1_int_active", {7'b0, INT_ACTIVE}, 8'h01);
    check("s1_intv_after_ack", {7'b0, INTV}, 8'h00);
    rd(BASE, 8'h00, 1'b1, "s1_pend_cleared");
    io_write(BASE + 8'd2, 8'h00);
    check("s1_eoi", {7'b0, INT_ACTIVE}, 8'h00);
    check("s1_intv_after_eoi", {7'b0, INTV}, 8'h00);

    // Priority between sources 1 and 3, re-raise after EOI
    io_write(BASE + 8'd1, 8'h0F);
    IRQ = 4'b1010;
    step(3);
    rd(BASE, 8'h0A, 1'b1, "s2_pend");
    step();
    check("s2_intv", {7'b0, INTV}, 8'h01);
    IRQ = 4'b0000;
    ack();
    check("s2_active_id", {5'b0, ACTIVE_ID}, 8'h01);
    rd(BASE, 8'h08, 1'b1, "s2_pend_after_ack");
    rd(BASE + 8'd2, 8'h01, 1'b1, "s2_id_port");
    check("s2_intv_active", {7'b0, INTV}, 8'h00);
    ack();
    check("s2_ack_in_active_id", {5'b0, ACTIVE_ID}, 8'h01);
    rd(BASE, 8'h08, 1'b1, "s2_ack_in_active_pend");
    io_write(BASE + 8'd2, 8'h00);
    check("s2_intv_eoi_edge", {7'b0, INTV}, 8'h00);
    check("s2_idle_after_eoi", {7'b0, INT_ACTIVE}, 8'h00);
    step();
    check("s2_reraise", {7'b0, INTV}, 8'h01);
    ack();
    check("s2_active_id2", {5'b0, ACTIVE_ID}, 8'h03);
    rd(BASE, 8'h00, 1'b1, "s2_pend_empty");
    io_write(BASE + 8'd2, 8'h00);
    ack();
    check("s2_ack_in_idle", {7'b0, INT_ACTIVE}, 8'h00);
    check("s2_ack_in_idle_id", {5'b0, ACTIVE_ID}, 8'h03);

    // Masking: pending but disabled, enable, then withdraw in REQUEST
    io_write(BASE + 8'd1, 8'h00);
    IRQ = 4'b0100;
    step(3);
    rd(BASE, 8'h04, 1'b1, "s3_pend");
    step();
    check("s3_masked_intv", {7'b0, INTV}, 8'h00);
    io_write(BASE + 8'd1, 8'h04);
    step();
    check("s3_unmask_intv", {7'b0, INTV}, 8'h01);
    io_write(BASE + 8'd1, 8'h00);
    step();
    check("s3_remask_intv", {7'b0, INTV}, 8'h00);
    check("s3_remask_active", {7'b0, INT_ACTIVE}, 8'h00);
    IRQ = 4'b0000;
    io_write(BASE, 8'h04);
    rd(BASE, 8'h00, 1'b1, "s3_w1c");

    // W1C collides with a new edge on the same bit: set wins
    IRQ = 4'b0010;
    step(3);
    rd(BASE, 8'h02, 1'b1, "s4_pend");
    IRQ = 4'b0000;
    step(3);
    IRQ = 4'b0010;
    step(2);
    PORT_ID  = BASE;
    OUT_PORT = 8'h02;
    IO_STRB  = 1'b1;
    step();
    IO_STRB  = 1'b0;
    rd(BASE, 8'h02, 1'b1, "s4_set_wins");
    rd(BASE + 8'd3, MISS_EN ? 8'h01 : 8'h00, 1'b1, "s4_miss_one");
    IRQ = 4'b0000;
    io_write(BASE, 8'h02);
    rd(BASE, 8'h00, 1'b1, "s4_w1c");

    // Reset in the middle of servicing source 2 with PEND = 05
    io_write(BASE + 8'd1, 8'h04);
    IRQ = 4'b0101;
    step(3);
    rd(BASE, 8'h05, 1'b1, "s5_pend");
    step();
    check("s5_intv", {7'b0, INTV}, 8'h01);
    IRQ = 4'b0000;
    ack();
    check("s5_active_id", {5'b0, ACTIVE_ID}, 8'h02);
    rd(BASE, 8'h01, 1'b1, "s5_pend_after_ack");
    step(2);
    IRQ = 4'b0100;
    step(3);
    rd(BASE, 8'h05, 1'b1, "s5_pend_in_active");
    check("s5_int_active", {7'b0, INT_ACTIVE}, 8'h01);
    IRQ = 4'b0000;
    #1;
    RESET = 1'b1;
    #1;
    check("s5_rst_intv", {7'b0, INTV}, 8'h00);
    check("s5_rst_int_active", {7'b0, INT_ACTIVE}, 8'h00);
    check("s5_rst_active_id", {5'b0, ACTIVE_ID}, 8'h00);
    step();
    RESET = 1'b0;
    rd(BASE, 8'h00, 1'b1, "s5_rst_pend");
    rd(BASE + 8'd1, 8'h00, 1'b1, "s5_rst_mask");
    rd(BASE + 8'd2, 8'h00, 1'b1, "s5_rst_id");
    step();

    // Missed-edge counter: 10 edges, then 290 more to saturate
    for (int k = 0; k < 10; k++) begin
      IRQ = 4'b0001;
      step(2);
      IRQ = 4'b0000;
      step(2);
    end
    step(3);
    rd(BASE + 8'd3, MISS_EN ? 8'h09 : 8'h00, 1'b1, "s6_miss_nine");
    step();
    for (int k = 0; k < 290; k++) begin
      IRQ = 4'b0001;
      step(2);
      IRQ = 4'b0000;
      step(2);
    end
    step(3);
    rd(BASE + 8'd3, MISS_EN ? 8'hFF : 8'h00, 1'b1, "s6_miss_sat");
    rd(BASE, 8'h01, 1'b1, "s6_pend");
    io_write(BASE + 8'd3, 8'h00);
    rd(BASE + 8'd3, 8'h00, 1'b1, "s6_miss_clr");
    check("s6_intv_masked", {7'b0, INTV}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
